// File: rtl/axi4stream_input_buffer.sv
// Packs consecutive narrow AXI4-Stream beats into one wide word.
// First beat is least significant; the final beat fills only the top slot's LSBs.
module axi4stream_input_buffer #(
  parameter int AXI_WIDTH         = 8,
  parameter int BUFFER_WIDTH      = 35,
  parameter int LAST_PACKET_WIDTH = 3
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [AXI_WIDTH-1:0]    tdata,
  input  logic                    tvalid,
  input  logic                    tlast,
  output logic                    tready,
  output logic [BUFFER_WIDTH-1:0] myBuffer,
  output logic                    valid
);

  localparam int NUM_BEATS =
    (BUFFER_WIDTH + AXI_WIDTH - 1) / AXI_WIDTH;
  localparam int CW =
    (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int AW = (NUM_BEATS - 1) * AXI_WIDTH;
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_BEATS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           asm_q, asm_d;
  logic [BUFFER_WIDTH-1:0] buf_q, buf_d;
  logic                    valid_q, valid_d;
  logic                    tready_q;
  logic                    accept;
  logic                    final_beat;

  assign accept     = tvalid && tready_q;
  assign final_beat = tlast || (cnt_q == LAST_SLOT);

  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    buf_d   = buf_q;
    valid_d = 1'b0;
    if (accept) begin
      if (final_beat) begin
        // Unwritten slots of a short frame are already zero in asm_q.
        buf_d   = {tdata[LAST_PACKET_WIDTH-1:0], asm_q};
        valid_d = 1'b1;
        cnt_d   = '0;
        asm_d   = '0;
      end else begin
        for (int k = 0; k < NUM_BEATS - 1; k++) begin
          if (cnt_q == CW'(k)) begin
            asm_d[k*AXI_WIDTH +: AXI_WIDTH] = tdata;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q    <= '0;
      asm_q    <= '0;
      buf_q    <= '0;
      valid_q  <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      buf_q    <= buf_d;
      valid_q  <= valid_d;
      tready_q <= 1'b1;
    end
  end

  assign tready   = tready_q;
  assign myBuffer = buf_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_axi4stream_input_buffer.sv
// Directed vector table plus randomized traffic against a frame-level model.
module tb_axi4stream_input_buffer;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [34:0] myBuffer;
  logic        valid;

  int tests  = 0;
  int failed = 0;

  always #5 aclk = ~aclk;

  axi4stream_input_buffer #(
    .AXI_WIDTH(8),
    .BUFFER_WIDTH(35),
    .LAST_PACKET_WIDTH(3)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .tdata(tdata),
    .tvalid(tvalid),
    .tlast(tlast),
    .tready(tready),
    .myBuffer(myBuffer),
    .valid(valid)
  );

  typedef struct {
    logic        rst;
    logic        tv;
    logic        tl;
    logic [7:0]  d;
    logic        ev;
    logic [34:0] eb;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(
    input logic rst, input logic tv, input logic tl,
    input logic [7:0] d, input logic ev,
    input logic [34:0] eb, input logic er);
    vec_t v;
    v.rst = rst; v.tv = tv; v.tl = tl; v.d = d;
    v.ev = ev; v.eb = eb; v.er = er;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [34:0] act, input logic [34:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %h, expected %h",
               name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic tv,
                       input logic tl, input logic [7:0] d);
    areset = rst;
    tvalid = tv;
    tlast  = tl;
    tdata  = d;
    @(posedge aclk);
    #1;
  endtask

  // Reference model state: beats of the open frame, output word, ready.
  logic [7:0]  m_beats[$];
  logic [34:0] m_buf;
  logic        m_rdy;
  logic        m_val;

  task automatic model_step(input logic rst, input logic tv,
                            input logic tl, input logic [7:0] d);
    logic [34:0] w;
    m_val = 1'b0;
    if (rst) begin
      m_beats.delete();
      m_buf = '0;
      m_rdy = 1'b0;
    end else begin
      if (tv && m_rdy) begin
        if (tl || m_beats.size() == 4) begin
          w = '0;
          foreach (m_beats[i]) w = w | (35'(m_beats[i]) << (8 * i));
          w = w | (35'(d & 8'h07) << 32);
          m_buf = w;
          m_val = 1'b1;
          m_beats.delete();
        end else begin
          m_beats.push_back(d);
        end
      end
      m_rdy = 1'b1;
    end
  endtask

  initial begin
    logic [34:0] b;
    areset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0;

    // reset with traffic present
    row(1, 1, 1, 8'hFF, 0, 0, 0);
    row(1, 1, 1, 8'hFF, 0, 0, 0);
    row(0, 0, 0, 8'h00, 0, 0, 1);
    // full frame
    row(0, 1, 0, 8'hEF, 0, 0, 1);
    row(0, 1, 0, 8'hBE, 0, 0, 1);
    row(0, 1, 0, 8'hAD, 0, 0, 1);
    row(0, 1, 0, 8'hDE, 0, 0, 1);
    b = 35'h7_DEAD_BEEF;
    row(0, 1, 1, 8'hFF, 1, b, 1);
    row(0, 0, 0, 8'h00, 0, b, 1);
    row(0, 0, 1, 8'h55, 0, b, 1);
    // gap plus short frame
    row(0, 1, 0, 8'hAA, 0, b, 1);
    row(0, 0, 0, 8'hBB, 0, b, 1);
    row(0, 1, 0, 8'hCC, 0, b, 1);
    row(0, 1, 0, 8'hDD, 0, b, 1);
    b = 35'h5_00DD_CCAA;
    row(0, 1, 1, 8'h05, 1, b, 1);
    row(0, 0, 0, 8'h00, 0, b, 1);
    // five beats without tlast
    row(0, 1, 0, 8'h11, 0, b, 1);
    row(0, 1, 0, 8'h22, 0, b, 1);
    row(0, 1, 0, 8'h33, 0, b, 1);
    row(0, 1, 0, 8'h44, 0, b, 1);
    b = 35'h7_4433_2211;
    row(0, 1, 0, 8'h0F, 1, b, 1);
    // back-to-back frames, counter restarted
    row(0, 1, 0, 8'h01, 0, b, 1);
    row(0, 1, 0, 8'h02, 0, b, 1);
    row(0, 1, 0, 8'h03, 0, b, 1);
    row(0, 1, 0, 8'h04, 0, b, 1);
    b = 35'h5_0403_0201;
    row(0, 1, 1, 8'h0D, 1, b, 1);
    row(0, 1, 0, 8'h10, 0, b, 1);
    row(0, 1, 0, 8'h20, 0, b, 1);
    row(0, 1, 0, 8'h30, 0, b, 1);
    row(0, 1, 0, 8'h40, 0, b, 1);
    b = 35'h6_4030_2010;
    row(0, 1, 1, 8'h0E, 1, b, 1);
    row(0, 0, 0, 8'h00, 0, b, 1);
    // mid-frame reset discards partial frame
    row(0, 1, 0, 8'hA1, 0, b, 1);
    row(0, 1, 0, 8'hA2, 0, b, 1);
    row(1, 0, 0, 8'h00, 0, 0, 0);
    row(0, 1, 0, 8'h99, 0, 0, 1);
    row(0, 1, 0, 8'h12, 0, 0, 1);
    row(0, 1, 0, 8'h34, 0, 0, 1);
    row(0, 1, 0, 8'h56, 0, 0, 1);
    row(0, 1, 0, 8'h78, 0, 0, 1);
    b = 35'h1_7856_3412;
    row(0, 1, 1, 8'hF1, 1, b, 1);
    // reset coinciding with a final beat
    row(0, 1, 0, 8'h01, 0, b, 1);
    row(0, 1, 0, 8'h02, 0, b, 1);
    row(0, 1, 0, 8'h03, 0, b, 1);
    row(0, 1, 0, 8'h04, 0, b, 1);
    row(1, 1, 1, 8'h07, 0, 0, 0);
    row(0, 0, 0, 8'h00, 0, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].tv, vecs[i].tl, vecs[i].d);
      chk("valid", i, 35'(valid), 35'(vecs[i].ev));
      chk("myBuffer", i, myBuffer, vecs[i].eb);
      chk("tready", i, 35'(tready), 35'(vecs[i].er));
    end

    // randomized traffic from a clean reset
    m_beats.delete();
    m_buf = '0; m_rdy = 1'b0; m_val = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic r, v, l;
      logic [7:0] d;
      r = (n < 2) || ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 70);
      l = ($urandom_range(0, 99) < 20);
      d = 8'($urandom);
      drive(r, v, l, d);
      model_step(r, v, l, d);
      chk("rnd_valid", n, 35'(valid), 35'(m_val));
      chk("rnd_myBuffer", n, myBuffer, m_buf);
      chk("rnd_tready", n, 35'(tready), 35'(m_rdy));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
